// File: rtl/eth_sync_fifo_ctrl_if.sv
// Bundle of push/pop handshake, status flags and external SRAM port for eth_sync_fifo_ctrl.
// The controller takes the slave view; the producer/consumer/SRAM side takes the master view.
interface eth_sync_fifo_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 88,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  afull;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  ovf;
  logic                  udf;
  logic                  sram_wr_cen;
  logic [ADDR_WIDTH-1:0] sram_wr_a;
  logic [DATA_WIDTH-1:0] sram_wr_d;
  logic                  sram_rd_cen;
  logic [ADDR_WIDTH-1:0] sram_rd_a;
  logic [DATA_WIDTH-1:0] sram_rd_q;

  modport master (
    output wr_en, wr_data, rd_en, sram_rd_q,
    input  full, afull, rd_data, empty, count, ovf, udf,
    input  sram_wr_cen, sram_wr_a, sram_wr_d, sram_rd_cen, sram_rd_a
  );

  modport slave (
    input  wr_en, wr_data, rd_en, sram_rd_q,
    output full, afull, rd_data, empty, count, ovf, udf,
    output sram_wr_cen, sram_wr_a, sram_wr_d, sram_rd_cen, sram_rd_a
  );
endinterface

// File: rtl/eth_sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller over an external 2-port SRAM with 1-cycle read
// latency; a 2-entry head/skid buffer hides that latency so the consumer can pop every cycle.
module eth_sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH   = 88,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned FIFO_DEPTH   = 1024,
  parameter int unsigned AFULL_THRESH = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_sync_fifo_ctrl_if.slave bus
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LpDepth = PtrW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LpAfull = PtrW'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_pend;
  logic [1:0]            r_buf_cnt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [ADDR_WIDTH:0]   w_ram_cnt;
  logic [2:0]            w_occ;
  logic [1:0]            w_buf_keep;
  logic [1:0]            w_buf_cnt_d;
  logic [DATA_WIDTH-1:0] w_head_d;
  logic [DATA_WIDTH-1:0] w_skid_d;
  logic [ADDR_WIDTH:0]   w_count_d;

  assign w_full    = (r_count == LpDepth);
  assign w_empty   = (r_buf_cnt == 2'd0);
  // Gated by rst_n so both chip enables stay inactive while reset is held.
  assign w_push    = rst_n & bus.wr_en & ~w_full;
  assign w_pop     = bus.rd_en & ~w_empty;
  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;

  // Entries buffered or in flight after this cycle's pop; issue only while that leaves a free slot.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
  assign w_issue = rst_n & (w_ram_cnt != '0) & (w_occ < 3'd2);

  assign w_buf_keep  = r_buf_cnt - {1'b0, w_pop};
  assign w_buf_cnt_d = w_buf_keep + {1'b0, r_pend};
  assign w_count_d   = r_count + PtrW'(w_push) - PtrW'(w_pop);

  always_comb begin
    w_head_d = r_head;
    w_skid_d = r_skid;
    if (w_pop) begin
      w_head_d = r_skid;
    end
    // Returning SRAM word goes to the first slot still free after the pop.
    if (r_pend) begin
      if (w_buf_keep == 2'd0) begin
        w_head_d = bus.sram_rd_q;
      end else begin
        w_skid_d = bus.sram_rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pend    <= 1'b0;
      r_buf_cnt <= 2'd0;
      r_head    <= '0;
      r_skid    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_pend    <= w_issue;
      r_buf_cnt <= w_buf_cnt_d;
      r_head    <= w_head_d;
      r_skid    <= w_skid_d;
      r_count   <= w_count_d;
      r_ovf     <= bus.wr_en & w_full;
      r_udf     <= bus.rd_en & w_empty;
    end
  end

  assign bus.full        = w_full;
  assign bus.afull       = (r_count >= LpAfull);
  assign bus.rd_data     = r_head;
  assign bus.empty       = w_empty;
  assign bus.count       = r_count;
  assign bus.ovf         = r_ovf;
  assign bus.udf         = r_udf;
  assign bus.sram_wr_cen = ~w_push;
  assign bus.sram_wr_a   = r_wr_ptr[ADDR_WIDTH-1:0];
  assign bus.sram_wr_d   = bus.wr_data;
  assign bus.sram_rd_cen = ~w_issue;
  assign bus.sram_rd_a   = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_eth_sync_fifo_ctrl.sv
// Self-checking bench for eth_sync_fifo_ctrl: directed vector table, fill/drain, wrap,
// random traffic against a queue model, and mid-stream reset. Includes a behavioural SRAM.
module tb_eth_sync_fifo_ctrl;
  localparam int DW = 88;
  localparam int AW = 10;

  typedef struct {
    bit          wr_en;
    bit          rd_en;
    logic [87:0] wr_data;
    bit          e_wr_cen;
    bit          e_rd_cen;
    bit          e_empty;
    logic [87:0] e_rd_data;
    logic [10:0] e_count;
    bit          e_ovf;
    bit          e_udf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  eth_sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  eth_sync_fifo_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (1024),
    .AFULL_THRESH(1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (!bus.sram_wr_cen) mem[bus.sram_wr_a] <= bus.sram_wr_d;
    if (!bus.sram_rd_cen) bus.sram_rd_q <= mem[bus.sram_rd_a];
  end

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic [87:0] d, input bit r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    #1;
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(bit w, bit r, logic [87:0] d, bit ercen, bit emp,
                              logic [87:0] rdd, logic [10:0] cnt, bit ov, bit ud);
    vec_t v;
    v.wr_en = w; v.rd_en = r; v.wr_data = d;
    v.e_wr_cen = !w; v.e_rd_cen = ercen; v.e_empty = emp;
    v.e_rd_data = rdd; v.e_count = cnt; v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  vec_t vecs[$];
  logic [DW-1:0] q[$];

  initial begin
    int errs, cerrs, wraps, afull_at, full_at;
    int wr_iss, rd_iss, derr, fl_err, em_err, cen_err;
    logic [9:0] prev_a;
    logic [DW-1:0] wv, rv, d;
    logic [95:0] tmp;
    bit w, r;
    n_pass = 0;
    n_total = 0;
    bus.sram_rd_q = '0;

    // wr, rd, data, rd_cen(pre-edge), empty, rd_data, count, ovf, udf (post-edge)
    vecs.push_back(mk(1, 0, 88'hA5, 1, 1, 0,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 1, 0,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 88'hA5, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0,      1, 1, 0,     0, 0, 0));
    vecs.push_back(mk(0, 1, 0,      1, 1, 0,     0, 0, 1));
    vecs.push_back(mk(1, 0, 88'h11, 1, 1, 0,     1, 0, 0));
    vecs.push_back(mk(1, 0, 88'h22, 0, 1, 0,     2, 0, 0));
    vecs.push_back(mk(1, 0, 88'h33, 0, 0, 88'h11, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0,      0, 0, 88'h22, 2, 0, 0));
    vecs.push_back(mk(1, 1, 88'h44, 1, 0, 88'h33, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 88'h33, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0,      1, 0, 88'h33, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0,      1, 0, 88'h44, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0,      1, 1, 0,     0, 0, 0));
    vecs.push_back(mk(0, 1, 0,      1, 1, 0,     0, 0, 1));

    // Reset state, including CENs held inactive while a push is requested in reset.
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.wr_data = 88'h5A;
    #3;
    check("rst_wr_cen", 88'(bus.sram_wr_cen), 88'(1));
    check("rst_rd_cen", 88'(bus.sram_rd_cen), 88'(1));
    do_reset();
    check("rst_empty", 88'(bus.empty), 88'(1));
    check("rst_full", 88'(bus.full), 88'(0));
    check("rst_afull", 88'(bus.afull), 88'(0));
    check("rst_count", 88'(bus.count), 88'(0));
    check("rst_ovf", 88'(bus.ovf), 88'(0));
    check("rst_udf", 88'(bus.udf), 88'(0));
    check("rst_rd_data", bus.rd_data, 88'(0));

    // Directed table.
    foreach (vecs[i]) begin
      drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      check($sformatf("v%0d_wr_cen", i), 88'(bus.sram_wr_cen), 88'(vecs[i].e_wr_cen));
      check($sformatf("v%0d_rd_cen", i), 88'(bus.sram_rd_cen), 88'(vecs[i].e_rd_cen));
      if (i == 0) begin
        check("v0_wr_a", 88'(bus.sram_wr_a), 88'(0));
        check("v0_wr_d", bus.sram_wr_d, 88'hA5);
      end
      cyc();
      check($sformatf("v%0d_empty", i), 88'(bus.empty), 88'(vecs[i].e_empty));
      check($sformatf("v%0d_count", i), 88'(bus.count), 88'(vecs[i].e_count));
      check($sformatf("v%0d_ovf", i), 88'(bus.ovf), 88'(vecs[i].e_ovf));
      check($sformatf("v%0d_udf", i), 88'(bus.udf), 88'(vecs[i].e_udf));
      if (!vecs[i].e_empty) check($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].e_rd_data);
    end

    // Fill 1..1024, then overflow, then drain with no gaps, then underflow.
    do_reset();
    afull_at = -1;
    full_at = -1;
    for (int i = 1; i <= 1024; i++) begin
      drive(1, 88'(i), 0);
      cyc();
      if (bus.afull && afull_at < 0) afull_at = int'(bus.count);
      if (bus.full && full_at < 0) full_at = int'(bus.count);
    end
    check("afull_rise_count", 88'(afull_at), 88'(1000));
    check("full_rise_count", 88'(full_at), 88'(1024));
    check("fill_count", 88'(bus.count), 88'(1024));
    drive(1, 88'hDEAD, 0);
    check("ovf_wr_cen_blocked", 88'(bus.sram_wr_cen), 88'(1));
    cyc();
    check("ovf_pulse", 88'(bus.ovf), 88'(1));
    check("ovf_count", 88'(bus.count), 88'(1024));
    drive(0, 0, 0);
    cyc();
    check("ovf_clear", 88'(bus.ovf), 88'(0));
    errs = 0;
    drive(0, 0, 1);
    for (int i = 1; i <= 1024; i++) begin
      if (bus.empty || bus.rd_data !== 88'(i)) errs++;
      cyc();
    end
    check("drain_seq_errors", 88'(errs), 88'(0));
    check("drain_empty", 88'(bus.empty), 88'(1));
    check("drain_count", 88'(bus.count), 88'(0));
    cyc();
    check("drain_udf", 88'(bus.udf), 88'(1));

    // Continuous push+pop across address wraps.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 88'(i), 0);
      cyc();
    end
    drive(0, 0, 0);
    repeat (3) cyc();
    wv = 88'd5;
    rv = 88'd0;
    errs = 0;
    cerrs = 0;
    wraps = 0;
    prev_a = '0;
    for (int i = 0; i < 3000; i++) begin
      drive(1, wv, 1);
      if (bus.empty || bus.rd_data !== rv) errs++;
      if (bus.count !== 11'd5) cerrs++;
      if (!bus.sram_rd_cen) begin
        if (prev_a == 10'd1023 && bus.sram_rd_a == 10'd0) wraps++;
        prev_a = bus.sram_rd_a;
      end
      cyc();
      wv++;
      rv++;
    end
    check("stream_data_errors", 88'(errs), 88'(0));
    check("stream_count_errors", 88'(cerrs), 88'(0));
    check("stream_rd_a_wraps", 88'(wraps), 88'(2));

    // Random traffic against a queue model.
    do_reset();
    q.delete();
    wr_iss = 0; rd_iss = 0; derr = 0; cerrs = 0; fl_err = 0; em_err = 0; cen_err = 0;
    for (int i = 0; i < 20000; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      tmp = {$urandom(), $urandom(), $urandom()};
      d = tmp[87:0];
      drive(w, d, r);
      if (bus.count !== 11'(q.size())) cerrs++;
      if (bus.full !== (q.size() == 1024)) fl_err++;
      if (q.size() == 0 && !bus.empty) em_err++;
      if (!bus.sram_rd_cen && (wr_iss - rd_iss) == 0) cen_err++;
      if (!bus.sram_wr_cen) wr_iss++;
      if (!bus.sram_rd_cen) rd_iss++;
      if (r && !bus.empty) begin
        if (q.size() == 0 || bus.rd_data !== q[0]) derr++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (w && !bus.full) q.push_back(d);
      cyc();
    end
    check("rand_data_errors", 88'(derr), 88'(0));
    check("rand_count_errors", 88'(cerrs), 88'(0));
    check("rand_full_errors", 88'(fl_err), 88'(0));
    check("rand_empty_errors", 88'(em_err), 88'(0));
    check("rand_rd_cen_errors", 88'(cen_err), 88'(0));

    // Reset with 5 entries held and reads in flight.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 88'(100 + i), 0);
      cyc();
    end
    drive(1, 88'd99, 0);
    check("mid_count_before", 88'(bus.count), 88'(5));
    rst_n = 1'b0;
    #1;
    check("mid_empty", 88'(bus.empty), 88'(1));
    check("mid_count", 88'(bus.count), 88'(0));
    check("mid_wr_cen", 88'(bus.sram_wr_cen), 88'(1));
    check("mid_rd_cen", 88'(bus.sram_rd_cen), 88'(1));
    drive(0, 0, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    drive(1, 88'd7, 0);
    cyc();
    drive(1, 88'd8, 0);
    cyc();
    drive(0, 0, 0);
    cyc();
    cyc();
    check("post_rst_count", 88'(bus.count), 88'(2));
    check("post_rst_empty", 88'(bus.empty), 88'(0));
    check("post_rst_first", bus.rd_data, 88'd7);
    drive(0, 0, 1);
    cyc();
    drive(0, 0, 0);
    check("post_rst_second", bus.rd_data, 88'd8);
    check("post_rst_count2", 88'(bus.count), 88'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
